// File: rtl/gpio_input_filter_if.sv
`default_nettype none
// =============================================================================
// gpio_input_filter_if : pin, configuration and status bundle of the GPIO
// input filter.  Revision: 1.0
// =============================================================================
interface gpio_input_filter_if #(
  parameter int NUM_GPIO = 32,
  parameter int CNT_W    = 16
);
  logic [NUM_GPIO-1:0] gpio_sync;
  logic [CNT_W-1:0]    filt_cycles;
  logic [NUM_GPIO-1:0] rise_en;
  logic [NUM_GPIO-1:0] fall_en;
  logic [NUM_GPIO-1:0] irq_mask;
  logic [NUM_GPIO-1:0] irq_clr;
  logic [NUM_GPIO-1:0] gpio_filt;
  logic [NUM_GPIO-1:0] irq_status;
  logic                irq;

  modport master (
    output gpio_sync, filt_cycles, rise_en, fall_en, irq_mask, irq_clr,
    input  gpio_filt, irq_status, irq
  );

  modport slave (
    input  gpio_sync, filt_cycles, rise_en, fall_en, irq_mask, irq_clr,
    output gpio_filt, irq_status, irq
  );
endinterface
`default_nettype wire

// File: rtl/gpio_input_filter.sv
`default_nettype none
// =============================================================================
// gpio_input_filter : per-pin glitch filter with sticky edge-event status
// and a masked level interrupt.  Revision: 1.0
// =============================================================================
module gpio_input_filter #(
  parameter int NUM_GPIO = 32,
  parameter int CNT_W    = 16
) (
  input  logic               sys_clk,
  input  logic               rst,
  gpio_input_filter_if.slave bus
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [NUM_GPIO-1:0] filt_q,   filt_d;
  logic [NUM_GPIO-1:0] status_q, status_d;
  logic [CNT_W-1:0]    cnt_q [NUM_GPIO];
  logic [CNT_W-1:0]    cnt_d [NUM_GPIO];
  logic [CNT_W-1:0]    w_n_eff_m1;
  logic [NUM_GPIO-1:0] w_qualify;
  logic [NUM_GPIO-1:0] w_rise;
  logic [NUM_GPIO-1:0] w_fall;

  // A programmed length of 0 behaves as 1, so the threshold is clamped at 0.
  assign w_n_eff_m1 = (bus.filt_cycles == '0) ? '0 : (bus.filt_cycles - C_CNT_ONE);

  always_comb begin
    filt_d    = filt_q;
    w_qualify = '0;
    w_rise    = '0;
    w_fall    = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.gpio_sync[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= w_n_eff_m1) begin
        // >= so a length lowered mid-count qualifies on the next differing sample
        w_qualify[i] = 1'b1;
        filt_d[i]    = bus.gpio_sync[i];
        cnt_d[i]     = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + C_CNT_ONE;
      end
      w_rise[i] = w_qualify[i] &  bus.gpio_sync[i];
      w_fall[i] = w_qualify[i] & ~bus.gpio_sync[i];
    end
    status_d = (status_q & ~bus.irq_clr) | (w_rise & bus.rise_en) | (w_fall & bus.fall_en);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      filt_q   <= '0;
      status_q <= '0;
      for (int i = 0; i < NUM_GPIO; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q   <= filt_d;
      status_q <= status_d;
      for (int i = 0; i < NUM_GPIO; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.gpio_filt  = filt_q;
  assign bus.irq_status = status_q;
  assign bus.irq        = |(status_q & bus.irq_mask);

endmodule
`default_nettype wire
